// File: rtl/tone_led_player.sv
// Plays one colour per handshake: lights the pad LED and drives its square-wave tone
// for a tick-aligned ON window, then stays silent for a GAP before taking the next colour.
module tone_led_player #(
    parameter int unsigned TICK_BITS  = 19,
    parameter int unsigned ON_TICKS   = 60,
    parameter int unsigned GAP_TICKS  = 20,
    parameter int unsigned TONE_HALF0 = 190840,
    parameter int unsigned TONE_HALF1 = 151686,
    parameter int unsigned TONE_HALF2 = 127551,
    parameter int unsigned TONE_HALF3 = 95556
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] colour_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [3:0] led,
    output logic       tone,
    output logic       busy,
    output logic       done
);
    localparam int unsigned MAX_TICKS = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int unsigned HALF_A    = (TONE_HALF0 > TONE_HALF1) ? TONE_HALF0 : TONE_HALF1;
    localparam int unsigned HALF_B    = (TONE_HALF2 > TONE_HALF3) ? TONE_HALF2 : TONE_HALF3;
    localparam int unsigned HALF_MAX  = (HALF_A > HALF_B) ? HALF_A : HALF_B;
    localparam int unsigned HALF_W    = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

    localparam logic [CNT_W-1:0]  ON_LAST    = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_TICKS - 1);
    localparam logic [HALF_W-1:0] HALF0_LAST = HALF_W'(TONE_HALF0 - 1);
    localparam logic [HALF_W-1:0] HALF1_LAST = HALF_W'(TONE_HALF1 - 1);
    localparam logic [HALF_W-1:0] HALF2_LAST = HALF_W'(TONE_HALF2 - 1);
    localparam logic [HALF_W-1:0] HALF3_LAST = HALF_W'(TONE_HALF3 - 1);

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ON, S_GAP} state_t;

    state_t              state;
    logic [TICK_BITS-1:0] prescaler;
    logic                 tick;
    logic [1:0]           colour;
    logic [CNT_W-1:0]     tick_cnt;
    logic [HALF_W-1:0]    half_cnt;
    logic [HALF_W-1:0]    half_last;

    // Free-running; the FSM aligns to it instead of clearing it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) prescaler <= '0;
        else       prescaler <= prescaler + 1'b1;
    end

    assign tick = &prescaler;

    always_comb begin
        half_last = HALF0_LAST;
        case (colour)
            2'd1:    half_last = HALF1_LAST;
            2'd2:    half_last = HALF2_LAST;
            2'd3:    half_last = HALF3_LAST;
            default: half_last = HALF0_LAST;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            colour    <= 2'd0;
            tick_cnt  <= '0;
            half_cnt  <= '0;
            led       <= 4'b0000;
            tone      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            ready_out <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (valid_in && ready_out) begin
                        colour    <= colour_in;
                        state     <= S_ALIGN;
                        ready_out <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_ALIGN: begin
                    if (tick) begin
                        state    <= S_ON;
                        tick_cnt <= '0;
                        half_cnt <= '0;
                        tone     <= 1'b0;
                        led      <= 4'b0001 << colour;
                    end
                end
                S_ON: begin
                    if (tick && tick_cnt == ON_LAST) begin
                        state    <= S_GAP;
                        tick_cnt <= '0;
                        led      <= 4'b0000;
                        tone     <= 1'b0;
                    end else begin
                        if (tick) tick_cnt <= tick_cnt + 1'b1;
                        if (half_cnt == half_last) begin
                            half_cnt <= '0;
                            tone     <= ~tone;
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (tick_cnt == GAP_LAST) begin
                            state     <= S_IDLE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            ready_out <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_led_player.sv
// Directed bench for tone_led_player with a short prescaler: per-colour playback table
// plus hand-written reset, back-to-back and tick-aligned accept sequences.
module tb_tone_led_player;
    logic       clock;
    logic       reset;
    logic [1:0] colour_in;
    logic       valid_in;
    logic       ready_out;
    logic [3:0] led;
    logic       tone;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int presc_m;

    tone_led_player #(
        .TICK_BITS(3), .ON_TICKS(2), .GAP_TICKS(1),
        .TONE_HALF0(2), .TONE_HALF1(3), .TONE_HALF2(4), .TONE_HALF3(5)
    ) dut (
        .clock(clock), .reset(reset), .colour_in(colour_in), .valid_in(valid_in),
        .ready_out(ready_out), .led(led), .tone(tone), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference prescaler: value seen by the next rising edge.
    always @(posedge clock or posedge reset) begin
        if (reset) presc_m <= 0;
        else       presc_m <= (presc_m + 1) % 8;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Bundle order: {ready_out, led[3:0], tone, busy, done}
    task automatic check(input string name, input int t, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got rdy/led/tone/busy/done=%b required %b", name, t, act, exp);
        end
    endtask

    task automatic play(input string name, input logic [1:0] col, input bit hold,
                        input bit inject, input logic [3:0] eled, input int half);
        int p, k, j, last;
        logic [7:0] exp;
        logic etone;
        colour_in = col;
        valid_in  = 1'b1;
        p = presc_m;
        k = (p == 7) ? 8 : 7 - p;
        last = hold ? k + 24 : k + 25;
        for (int t = 0; t <= last; t++) begin
            @(posedge clock);
            @(negedge clock);
            if (t < k) begin
                exp = {1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
            end else if (t < k + 16) begin
                j = t - k;
                etone = ((j / half) % 2) != 0;
                exp = {1'b0, eled, etone, 1'b1, 1'b0};
            end else if (t < k + 24) begin
                exp = {1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
            end else if (t == k + 24) begin
                exp = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b1};
            end else begin
                exp = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
            end
            check(name, t, {ready_out, led, tone, busy, done}, exp);
            if (t == 0) begin
                if (hold) colour_in = ~col;
                else      valid_in  = 1'b0;
            end
            if (inject && t == k + 4) begin
                valid_in  = 1'b1;
                colour_in = 2'd3;
            end
            if (inject && t == k + 5) begin
                valid_in  = 1'b0;
                colour_in = col;
            end
        end
    endtask

    typedef struct {
        string      name;
        logic [1:0] col;
        bit         hold;
        bit         inject;
        int         align;
        logic [3:0] eled;
        int         half;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int guard;
        vecs[0] = '{"col2_after_reset", 2'd2, 1'b0, 1'b0, -1, 4'b0100, 4};
        vecs[1] = '{"col0_align1",      2'd0, 1'b0, 1'b0,  6, 4'b0001, 2};
        vecs[2] = '{"col1_tick_accept", 2'd1, 1'b0, 1'b1,  7, 4'b0010, 3};
        vecs[3] = '{"col1_hold",        2'd1, 1'b1, 1'b0,  3, 4'b0010, 3};
        vecs[4] = '{"col3_back2back",   2'd3, 1'b0, 1'b0, -1, 4'b1000, 5};
        vecs[5] = '{"col2_align7",      2'd2, 1'b0, 1'b0,  0, 4'b0100, 4};

        reset     = 1'b1;
        colour_in = 2'd0;
        valid_in  = 1'b0;
        #12;
        check("reset_state", 0, {ready_out, led, tone, busy, done}, 8'b1_0000_0_0_0);
        @(negedge clock);
        reset = 1'b0;

        // Reset in the middle of an ON window.
        colour_in = 2'd2;
        valid_in  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        valid_in = 1'b0;
        guard = 0;
        while (led == 4'b0000 && guard < 12) begin
            @(negedge clock);
            guard++;
        end
        checks++;
        if (led == 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_on_wait: led stayed %b, required 0100 within 12 cycles", led);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #2;
        check("reset_mid_on", 0, {ready_out, led, tone, busy, done}, 8'b1_0000_0_0_0);
        @(negedge clock);
        check("reset_held", 1, {ready_out, led, tone, busy, done}, 8'b1_0000_0_0_0);
        reset = 1'b0;

        // First entry is accepted straight after release, so its alignment proves the prescaler restarted.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].align >= 0) begin
                guard = 0;
                while (presc_m != vecs[i].align && guard < 16) begin
                    @(negedge clock);
                    guard++;
                end
            end
            play(vecs[i].name, vecs[i].col, vecs[i].hold, vecs[i].inject, vecs[i].eled, vecs[i].half);
        end

        repeat (10) @(negedge clock);
        check("idle_after_ignore", 0, {ready_out, led, tone, busy, done}, 8'b1_0000_0_0_0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
